// File: rtl/usb_packet_rx_pkg.sv
// Shared types and constants for the USB packet receiver: FSM states, PID classes,
// CRC parameters/residuals, payload limits and error codes.
package usb_packet_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PID  = 2'd1,
        ST_BODY = 2'd2,
        ST_DONE = 2'd3
    } rx_state_e;

    // Packet class is carried in pid[1:0]
    localparam logic [1:0] CLS_SPECIAL   = 2'b00;
    localparam logic [1:0] CLS_TOKEN     = 2'b01;
    localparam logic [1:0] CLS_HANDSHAKE = 2'b10;
    localparam logic [1:0] CLS_DATA      = 2'b11;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;

    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    localparam int         MAX_PAYLOAD = 1023;
    localparam logic [10:0] MAX_BODY   = 11'(MAX_PAYLOAD + 2);

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_PID         = 3'd1;
    localparam logic [2:0] ERR_CRC         = 3'd2;
    localparam logic [2:0] ERR_ALIGN       = 3'd3;
    localparam logic [2:0] ERR_LINE        = 3'd4;
    localparam logic [2:0] ERR_LENGTH      = 3'd5;
    localparam logic [2:0] ERR_UNSUPPORTED = 3'd6;

    function automatic logic pid_check(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

endpackage

// File: rtl/usb_crc_serial.sv
// Serial CRC, one bit per enabled cycle, MSB-feedback form. The crc output already
// includes the bit presented this cycle so an end-of-packet check needs no extra cycle.
module usb_crc_serial #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = '0,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] crc
);

    logic [WIDTH-1:0] crc_q;
    logic             fb;

    always_comb begin
        fb  = crc_q[WIDTH-1] ^ din;
        crc = crc_q;
        if (clear) begin
            crc = INIT;
        end else if (en) begin
            crc = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc;
        end
    end

endmodule

// File: rtl/usb_packet_rx.sv
// USB packet receiver: takes de-stuffed bits from the bit-level layer, checks PID and CRC,
// emits PID, payload bytes (through a 2-byte skid buffer that swallows the CRC) and token fields.
module usb_packet_rx
    import usb_packet_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_start,
    input  logic       rx_status,
    input  logic       rx_bit,
    input  logic       rx_finish,
    input  logic       rx_error,
    output logic       pid_valid,
    output logic [3:0] pid,
    output logic       data_valid,
    output logic [7:0] data,
    output logic       tok_valid,
    output logic [6:0] tok_addr,
    output logic [3:0] tok_endp,
    output logic       pkt_done,
    output logic       pkt_ok,
    output logic [2:0] err_code,
    output rx_state_e  state_dbg
);

    rx_state_e   state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [10:0] body_cnt_q, body_cnt_d;
    logic [7:0]  b0_q, b1_q, b0_d, b1_d;
    logic        pid_ok_q, pid_ok_d;
    logic        ovf_q, ovf_d;
    logic        err_q;

    logic        active, err_rise, take, byte_done, body_byte, overflow;
    logic        pid_byte_ok, pid_byte_bad, pkt_end, emit, crc_en;
    logic        len_bad, crc_bad;
    logic [3:0]  pid_eff;
    logic [1:0]  cls;
    logic [2:0]  end_code;
    logic [4:0]  crc5;
    logic [15:0] crc16;

    usb_crc_serial #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
        .clk(clk), .rst(rst), .clear(rx_start), .en(crc_en), .din(rx_bit), .crc(crc5)
    );

    usb_crc_serial #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
        .clk(clk), .rst(rst), .clear(rx_start), .en(crc_en), .din(rx_bit), .crc(crc16)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_start) begin
            state_d = ST_PID;
        end else if (pkt_end) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_PID: begin
                    if (pid_byte_ok)       state_d = ST_BODY;
                    else if (pid_byte_bad) state_d = ST_DONE;
                end
                ST_BODY: begin
                    if (overflow) state_d = ST_DONE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // A bit arriving with rx_finish is folded in first, so every end check uses the *_d values.
    always_comb begin
        active       = (state_q != ST_IDLE);
        err_rise     = rx_error && !err_q;
        take         = rx_status && (state_q == ST_PID || state_q == ST_BODY);
        byte_done    = take && (bit_cnt_q == 3'd7);
        sr_d         = take ? {rx_bit, sr_q[7:1]} : sr_q;
        bit_cnt_d    = (active && rx_status) ? bit_cnt_q + 3'd1 : bit_cnt_q;
        pid_byte_ok  = (state_q == ST_PID) && byte_done && pid_check(sr_d);
        pid_byte_bad = (state_q == ST_PID) && byte_done && !pid_check(sr_d);
        body_byte    = (state_q == ST_BODY) && byte_done;
        overflow     = body_byte && (body_cnt_q == MAX_BODY);
        crc_en       = take && (state_q == ST_BODY);
        pkt_end      = active && (rx_finish || err_rise) && !rx_start;
        pid_ok_d     = pid_ok_q || pid_byte_ok;
        ovf_d        = ovf_q || overflow;
        pid_eff      = (state_q == ST_PID) ? sr_d[3:0] : pid;
        cls          = pid_eff[1:0];

        body_cnt_d = body_cnt_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        if (body_byte && !overflow) begin
            body_cnt_d = body_cnt_q + 11'd1;
            b0_d       = b1_q;
            b1_d       = sr_d;
        end
        emit = body_byte && !overflow && (cls == CLS_DATA) && (body_cnt_q >= 11'd2);

        len_bad = 1'b0;
        crc_bad = 1'b0;
        case (cls)
            CLS_TOKEN: begin
                len_bad = (body_cnt_d != 11'd2) || ovf_d;
                crc_bad = (crc5 != CRC5_RESIDUAL);
            end
            CLS_HANDSHAKE: len_bad = (body_cnt_d != 11'd0) || ovf_d;
            CLS_DATA: begin
                len_bad = (body_cnt_d < 11'd2) || ovf_d;
                crc_bad = (crc16 != CRC16_RESIDUAL);
            end
            default: len_bad = 1'b0;
        endcase

        if (err_rise)                end_code = ERR_LINE;
        else if (bit_cnt_d != 3'd0)  end_code = ERR_ALIGN;
        else if (!pid_ok_d)          end_code = ERR_PID;
        else if (cls == CLS_SPECIAL) end_code = ERR_UNSUPPORTED;
        else if (len_bad)            end_code = ERR_LENGTH;
        else if (crc_bad)            end_code = ERR_CRC;
        else                         end_code = ERR_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            body_cnt_q <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            pid_ok_q   <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= rx_error;
            if (rx_start) begin
                sr_q       <= '0;
                bit_cnt_q  <= '0;
                body_cnt_q <= '0;
                b0_q       <= '0;
                b1_q       <= '0;
                pid_ok_q   <= 1'b0;
                ovf_q      <= 1'b0;
            end else begin
                sr_q       <= sr_d;
                bit_cnt_q  <= bit_cnt_d;
                body_cnt_q <= body_cnt_d;
                b0_q       <= b0_d;
                b1_q       <= b1_d;
                pid_ok_q   <= pid_ok_d;
                ovf_q      <= ovf_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pid_valid  <= 1'b0;
            pid        <= '0;
            data_valid <= 1'b0;
            data       <= '0;
            tok_valid  <= 1'b0;
            tok_addr   <= '0;
            tok_endp   <= '0;
            pkt_done   <= 1'b0;
            pkt_ok     <= 1'b0;
            err_code   <= '0;
        end else begin
            pid_valid  <= pid_byte_ok && !rx_start;
            data_valid <= emit && !rx_start;
            pkt_done   <= pkt_end;
            pkt_ok     <= pkt_end && (end_code == ERR_NONE);
            err_code   <= pkt_end ? end_code : ERR_NONE;
            tok_valid  <= pkt_end && (end_code == ERR_NONE) && (cls == CLS_TOKEN);
            if (pid_byte_ok && !rx_start) pid <= sr_d[3:0];
            if (emit && !rx_start)        data <= b0_q;
            if (pkt_end && (end_code == ERR_NONE) && (cls == CLS_TOKEN)) begin
                tok_addr <= b0_d[6:0];
                tok_endp <= {b1_d[2:0], b0_d[7]};
            end
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_usb_packet_rx.sv
// Directed bench for usb_packet_rx: each task drives one scenario and checks inline.
module tb_usb_packet_rx;
    import usb_packet_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst, rx_start, rx_status, rx_bit, rx_finish, rx_error;
    logic       pid_valid, data_valid, tok_valid, pkt_done, pkt_ok;
    logic [3:0] pid, tok_endp;
    logic [7:0] data;
    logic [6:0] tok_addr;
    logic [2:0] err_code;
    rx_state_e  state_dbg;

    int checks = 0;
    int errors = 0;

    // Observations gathered by the monitor
    logic [7:0] data_log[$];
    int         n_pid = 0;
    int         n_tok = 0;
    int         n_done = 0;
    logic [3:0] last_pid = '0;

    // Expected payload for the current scenario
    logic [7:0] exp_q[$];

    // Values captured on the cycle after rx_finish
    logic       cap_done, cap_ok, cap_tok;
    logic [2:0] cap_err;
    logic [6:0] cap_addr;
    logic [3:0] cap_endp;

    usb_packet_rx dut (
        .clk(clk), .rst(rst), .rx_start(rx_start), .rx_status(rx_status), .rx_bit(rx_bit),
        .rx_finish(rx_finish), .rx_error(rx_error), .pid_valid(pid_valid), .pid(pid),
        .data_valid(data_valid), .data(data), .tok_valid(tok_valid), .tok_addr(tok_addr),
        .tok_endp(tok_endp), .pkt_done(pkt_done), .pkt_ok(pkt_ok), .err_code(err_code),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) data_log.push_back(data);
        if (pid_valid) begin
            n_pid++;
            last_pid = pid;
        end
        if (tok_valid) n_tok++;
        if (pkt_done) n_done++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Reflected-form USB CRCs used only to build legal stimulus
    function automatic logic [15:0] crc16_usb(input logic [7:0] pl[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (pl[k]) begin
            for (int i = 0; i < 8; i++) begin
                if (c[0] ^ pl[k][i]) c = (c >> 1) ^ 16'hA001;
                else                 c = c >> 1;
            end
        end
        return ~c;
    endfunction

    function automatic logic [4:0] crc5_usb(input logic [10:0] v);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (c[0] ^ v[i]) c = (c >> 1) ^ 5'h14;
            else             c = c >> 1;
        end
        return ~c;
    endfunction

    task automatic send_bit(input logic b);
        rx_status = 1'b1;
        rx_bit    = b;
        @(posedge clk); #1;
        rx_status = 1'b0;
        rx_bit    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic start_pkt();
        rx_start = 1'b1;
        @(posedge clk); #1;
        rx_start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic finish_pkt();
        rx_finish = 1'b1;
        @(posedge clk); #1;
        rx_finish = 1'b0;
        @(negedge clk);
        cap_done = pkt_done;
        cap_ok   = pkt_ok;
        cap_err  = err_code;
        cap_tok  = tok_valid;
        cap_addr = tok_addr;
        cap_endp = tok_endp;
        @(posedge clk); #1;
    endtask

    task automatic send_data_pkt(input logic [7:0] pid_byte, input logic [7:0] pl[$],
                                 input logic [7:0] corrupt);
        logic [15:0] c;
        c = crc16_usb(pl);
        send_byte(pid_byte);
        foreach (pl[k]) send_byte(pl[k]);
        send_byte(c[7:0] ^ corrupt);
        send_byte(c[15:8]);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_start = 1'b0; rx_status = 1'b0; rx_bit = 1'b0;
        rx_finish = 1'b0; rx_error = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pid_valid, data_valid, tok_valid, pkt_done, pkt_ok} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {pid_valid, data_valid, tok_valid, pkt_done, pkt_ok});
        end
        checks++;
        if ({pid, data, tok_addr, tok_endp, err_code} !== 26'b0) begin
            errors++;
            $display("FAIL reset_fields: got %h expected 0", {pid, data, tok_addr, tok_endp, err_code});
        end
        checks++;
        if (state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_ignore();
        int p0, d0, n0;
        p0 = n_pid; d0 = data_log.size(); n0 = n_done;
        send_byte(8'hD2);
        finish_pkt();
        checks++;
        if (cap_done !== 1'b0 || n_pid != p0 || data_log.size() != d0 || n_done != n0) begin
            errors++;
            $display("FAIL idle_ignore: done=%b pid_pulses=%0d data=%0d expected no outputs",
                     cap_done, n_pid - p0, data_log.size() - d0);
        end
    endtask

    task automatic test_ack();
        int p0, d0;
        p0 = n_pid; d0 = data_log.size();
        start_pkt();
        send_byte(8'hD2);
        finish_pkt();
        checks++;
        if (n_pid != p0 + 1 || last_pid !== 4'h2) begin
            errors++;
            $display("FAIL ack_pid: pulses=%0d pid=%h expected 1 pulse pid=2", n_pid - p0, last_pid);
        end
        checks++;
        if (cap_done !== 1'b1 || cap_ok !== 1'b1 || cap_err !== 3'd0) begin
            errors++;
            $display("FAIL ack_done: done=%b ok=%b err=%0d expected 1 1 0", cap_done, cap_ok, cap_err);
        end
        checks++;
        if (data_log.size() != d0) begin
            errors++;
            $display("FAIL ack_nodata: got %0d bytes expected 0", data_log.size() - d0);
        end
    endtask

    task automatic test_token();
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [4:0]  c5;
        start_pkt();
        send_byte(8'h2D); send_byte(8'h00); send_byte(8'h10);
        finish_pkt();
        checks++;
        if (cap_tok !== 1'b1 || cap_addr !== 7'd0 || cap_endp !== 4'd0 || cap_ok !== 1'b1) begin
            errors++;
            $display("FAIL setup_token: tok=%b addr=%h endp=%h ok=%b expected 1 0 0 1",
                     cap_tok, cap_addr, cap_endp, cap_ok);
        end
        start_pkt();
        send_byte(8'h2D); send_byte(8'h00); send_byte(8'h11);
        finish_pkt();
        checks++;
        if (cap_tok !== 1'b0 || cap_err !== 3'd2) begin
            errors++;
            $display("FAIL token_badcrc: tok=%b err=%0d expected 0 2", cap_tok, cap_err);
        end
        addr = 7'h3A; endp = 4'hA;
        c5 = crc5_usb({endp, addr});
        start_pkt();
        send_byte(8'h69);
        send_byte({endp[0], addr});
        send_byte({c5, endp[3:1]});
        finish_pkt();
        checks++;
        if (cap_tok !== 1'b1 || cap_addr !== addr || cap_endp !== endp || cap_err !== 3'd0) begin
            errors++;
            $display("FAIL token_fields: tok=%b addr=%h endp=%h err=%0d expected 1 3a a 0",
                     cap_tok, cap_addr, cap_endp, cap_err);
        end
        start_pkt();
        send_byte(8'h2D);
        finish_pkt();
        checks++;
        if (cap_err !== 3'd5 || cap_tok !== 1'b0) begin
            errors++;
            $display("FAIL token_short: err=%0d tok=%b expected 5 0", cap_err, cap_tok);
        end
    endtask

    task automatic test_data();
        int d0;
        logic [7:0] pl[$];
        logic [15:0] c;
        d0 = data_log.size();
        start_pkt();
        send_byte(8'hC3); send_byte(8'h00); send_byte(8'h00);
        finish_pkt();
        checks++;
        if (cap_ok !== 1'b1 || cap_err !== 3'd0 || data_log.size() != d0) begin
            errors++;
            $display("FAIL data0_empty: ok=%b err=%0d bytes=%0d expected 1 0 0",
                     cap_ok, cap_err, data_log.size() - d0);
        end
        start_pkt();
        send_byte(8'hC3); send_byte(8'h00); send_byte(8'h01);
        finish_pkt();
        checks++;
        if (cap_err !== 3'd2 || cap_ok !== 1'b0) begin
            errors++;
            $display("FAIL data0_badcrc: err=%0d ok=%b expected 2 0", cap_err, cap_ok);
        end
        // Payload 11 22 33: the first byte must appear one cycle after the third body byte
        pl = '{8'h11, 8'h22, 8'h33};
        c = crc16_usb(pl);
        exp_q = '{8'h11, 8'h22, 8'h33};
        d0 = data_log.size();
        start_pkt();
        send_byte(8'h4B); send_byte(8'h11); send_byte(8'h22);
        for (int i = 0; i < 7; i++) send_bit(pl[2][i]);
        rx_status = 1'b1; rx_bit = pl[2][7];
        @(posedge clk); #1;
        rx_status = 1'b0;
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b1 || data !== 8'h11) begin
            errors++;
            $display("FAIL data_latency: valid=%b data=%h expected 1 11", data_valid, data);
        end
        @(posedge clk); #1;
        send_byte(c[7:0]); send_byte(c[15:8]);
        finish_pkt();
        checks++;
        if (cap_ok !== 1'b1 || data_log.size() != d0 + exp_q.size()) begin
            errors++;
            $display("FAIL data1_payload: ok=%b bytes=%0d expected 1 %0d",
                     cap_ok, data_log.size() - d0, exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                checks++;
                if (data_log[d0 + k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL data1_byte%0d: got %h expected %h", k, data_log[d0 + k], exp_q[k]);
                end
            end
        end
        pl = '{8'h5A};
        start_pkt();
        send_data_pkt(8'hC3, pl, 8'h04);
        finish_pkt();
        checks++;
        if (cap_err !== 3'd2) begin
            errors++;
            $display("FAIL data_flipbit: err=%0d expected 2", cap_err);
        end
    endtask

    task automatic test_pid_error();
        int p0;
        p0 = n_pid;
        start_pkt();
        send_byte(8'hD3);
        send_byte(8'hFF);
        finish_pkt();
        checks++;
        if (cap_err !== 3'd1 || cap_done !== 1'b1 || n_pid != p0) begin
            errors++;
            $display("FAIL pid_error: err=%0d done=%b pid_pulses=%0d expected 1 1 0",
                     cap_err, cap_done, n_pid - p0);
        end
        start_pkt();
        send_byte(8'hD2);
        finish_pkt();
        checks++;
        if (cap_ok !== 1'b1 || n_pid != p0 + 1) begin
            errors++;
            $display("FAIL ack_after_pid_error: ok=%b pid_pulses=%0d expected 1 1", cap_ok, n_pid - p0);
        end
    endtask

    task automatic test_errors();
        int n0;
        start_pkt();
        send_byte(8'hD2);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        finish_pkt();
        checks++;
        if (cap_err !== 3'd3) begin
            errors++;
            $display("FAIL align_error: err=%0d expected 3", cap_err);
        end
        start_pkt();
        send_byte(8'hD2); send_byte(8'h00);
        finish_pkt();
        checks++;
        if (cap_err !== 3'd5) begin
            errors++;
            $display("FAIL handshake_len: err=%0d expected 5", cap_err);
        end
        start_pkt();
        send_byte(8'hB4);
        finish_pkt();
        checks++;
        if (cap_err !== 3'd6) begin
            errors++;
            $display("FAIL unsupported_pid: err=%0d expected 6", cap_err);
        end
        start_pkt();
        send_byte(8'hC3); send_byte(8'h00);
        finish_pkt();
        checks++;
        if (cap_err !== 3'd5) begin
            errors++;
            $display("FAIL data_short: err=%0d expected 5", cap_err);
        end
        n0 = n_done;
        start_pkt();
        send_byte(8'hC3);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx_error = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (pkt_done !== 1'b1 || err_code !== 3'd4 || pkt_ok !== 1'b0) begin
            errors++;
            $display("FAIL line_error: done=%b err=%0d ok=%b expected 1 4 0", pkt_done, err_code, pkt_ok);
        end
        repeat (4) @(posedge clk);
        #1 rx_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (n_done != n0 + 1 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL line_error_once: done_pulses=%0d state=%0d expected 1 %0d",
                     n_done - n0, state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_coincident();
        logic [7:0] b;
        b = 8'hD2;
        start_pkt();
        for (int i = 0; i < 7; i++) send_bit(b[i]);
        rx_status = 1'b1; rx_bit = b[7]; rx_finish = 1'b1;
        @(posedge clk); #1;
        rx_status = 1'b0; rx_finish = 1'b0;
        @(negedge clk);
        checks++;
        if (pid_valid !== 1'b1 || pkt_done !== 1'b1 || pkt_ok !== 1'b1 || err_code !== 3'd0) begin
            errors++;
            $display("FAIL coincident_finish: pid_valid=%b done=%b ok=%b err=%0d expected 1 1 1 0",
                     pid_valid, pkt_done, pkt_ok, err_code);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_restart();
        int d0, n0;
        logic [7:0] pl[$];
        d0 = data_log.size(); n0 = n_done;
        start_pkt();
        send_byte(8'hC3); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        pl = '{8'h55};
        start_pkt();
        send_data_pkt(8'h4B, pl, 8'h00);
        finish_pkt();
        checks++;
        if (data_log.size() != d0 + 2 || n_done != n0 + 1 || cap_ok !== 1'b1) begin
            errors++;
            $display("FAIL restart_counts: bytes=%0d done_pulses=%0d ok=%b expected 2 1 1",
                     data_log.size() - d0, n_done - n0, cap_ok);
        end else begin
            checks++;
            if (data_log[d0] !== 8'hAA || data_log[d0 + 1] !== 8'h55) begin
                errors++;
                $display("FAIL restart_data: got %h %h expected aa 55", data_log[d0], data_log[d0 + 1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        n0 = n_done;
        start_pkt();
        send_byte(8'hC3);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rx_finish = 1'b1;
        @(posedge clk); #1;
        rx_finish = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (n_done != n0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid_packet: done_pulses=%0d state=%0d expected 0 %0d",
                     n_done - n0, state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_max_length();
        int d0;
        logic [7:0] pl[$];
        pl = {};
        for (int i = 0; i < MAX_PAYLOAD; i++) pl.push_back(8'(i * 7 + 1));
        d0 = data_log.size();
        start_pkt();
        send_data_pkt(8'hC3, pl, 8'h00);
        finish_pkt();
        checks++;
        if (cap_ok !== 1'b1 || data_log.size() != d0 + MAX_PAYLOAD) begin
            errors++;
            $display("FAIL max_payload: ok=%b err=%0d bytes=%0d expected 1 0 %0d",
                     cap_ok, cap_err, data_log.size() - d0, MAX_PAYLOAD);
        end else begin
            checks++;
            if (data_log[d0 + MAX_PAYLOAD - 1] !== pl[MAX_PAYLOAD - 1]) begin
                errors++;
                $display("FAIL max_payload_last: got %h expected %h",
                         data_log[d0 + MAX_PAYLOAD - 1], pl[MAX_PAYLOAD - 1]);
            end
        end
        d0 = data_log.size();
        start_pkt();
        send_byte(8'hC3);
        for (int i = 0; i < MAX_PAYLOAD + 3; i++) send_byte(8'h00);
        finish_pkt();
        checks++;
        if (cap_err !== 3'd5 || data_log.size() != d0 + MAX_PAYLOAD) begin
            errors++;
            $display("FAIL overflow: err=%0d bytes=%0d expected 5 %0d",
                     cap_err, data_log.size() - d0, MAX_PAYLOAD);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_ack();
        test_token();
        test_data();
        test_pid_error();
        test_errors();
        test_coincident();
        test_restart();
        test_reset_mid();
        test_max_length();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
